load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-port load/store unit: takes RV32I-style byte/half/word requests, checks legality,
// drives lane strobes to a word-wide data memory and returns extended load data.
module load_store_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_dat,
  output logic [3:0]        mem_w_enb,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [3:0]        mem_r_enb,
  input  logic [DATA_W-1:0] mem_r_dat
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_hs;
  logic                w_illegal;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load;

  assign w_hs = req_valid && req_ready;

  // Legality is judged on the live request so an error can go straight to RESP.
  always_comb begin
    w_illegal = (req_addr[31:ADDR_W] != '0);
    case (req_funct3)
      F3_B:  ;
      F3_H:  if (req_addr[0]) w_illegal = 1'b1;
      F3_W:  if (req_addr[1:0] != 2'b00) w_illegal = 1'b1;
      F3_BU: if (req_we) w_illegal = 1'b1;
      F3_HU: if (req_we || req_addr[0]) w_illegal = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_byte = mem_r_dat[8*r_addr[1:0] +: 8];
  assign w_half = r_addr[1] ? mem_r_dat[31:16] : mem_r_dat[15:0];

  always_comb begin
    case (r_funct3)
      F3_B:    w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_BU:   w_load = {{(DATA_W-8){1'b0}}, w_byte};
      F3_H:    w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_HU:   w_load = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load = mem_r_dat;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_addr   <= req_addr[ADDR_W-1:0];
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_illegal;
      end
      if (r_state == READ) r_rdata <= w_load;
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_w_addr = '0;
    mem_w_dat  = '0;
    mem_w_enb  = 4'b0000;
    mem_r_addr = '0;
    mem_r_enb  = 4'b0000;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          if (w_illegal)   w_next = RESP;
          else if (req_we) w_next = WRITE;
          else             w_next = READ;
        end
      end
      WRITE: begin
        w_next     = RESP;
        mem_w_addr = r_addr;
        case (r_funct3)
          F3_B: begin
            mem_w_enb = 4'b0001 << r_addr[1:0];
            mem_w_dat = {(DATA_W/8){r_wdata[7:0]}};
          end
          F3_H: begin
            mem_w_enb = 4'b0011 << r_addr[1:0];
            mem_w_dat = {(DATA_W/16){r_wdata[15:0]}};
          end
          default: begin
            mem_w_enb = 4'b1111;
            mem_w_dat = r_wdata;
          end
        endcase
      end
      READ: begin
        w_next     = RESP;
        mem_r_enb  = 4'b1111;
        mem_r_addr = {2'b00, r_addr[ADDR_W-1:2]};
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_we is kept for traceability of the latched request; the FSM path already encodes it.
  logic w_unused;
  assign w_unused = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued at request time and
// popped when the unit presents resp_valid; a behavioural memory sits behind the strobes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [11:0] mem_w_addr, mem_r_addr;
  logic [31:0] mem_w_dat, mem_r_dat;
  logic [3:0]  mem_w_enb, mem_r_enb;

  load_store_unit #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
    .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb), .mem_r_dat(mem_r_dat)
  );

  always #5 clk = ~clk;

  logic [31:0] dut_mem [1024];
  logic [31:0] ref_mem [1024];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_w_enb[i]) dut_mem[mem_w_addr[11:2]][8*i +: 8] <= mem_w_dat[8*i +: 8];
  end
  assign mem_r_dat = dut_mem[mem_r_addr[9:0]];

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (a[31:12] != 0) return 1'b1;
    case (f3)
      3'b000: return 1'b0;
      3'b001: return a[0];
      3'b010: return a[1:0] != 2'b00;
      3'b100: return we;
      3'b101: return we || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[a[11:2]];
    b = 8'((w >> (8 * a[1:0])) & 32'hFF);
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    exp_t        e;
    logic        ill;
    int          t;
    logic [3:0]  x_enb;
    logic [31:0] x_dat;
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    ill     = is_illegal(we, f3, a);
    e.err   = ill;
    e.rdata = (ill || we) ? 32'h0 : load_val(f3, a);
    sb_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ill) begin
      check("err_no_strobe", {24'h0, mem_w_enb, mem_r_enb}, 32'h0);
    end else begin
      if (we) begin
        case (f3)
          3'b000:  begin x_enb = 4'b0001 << a[1:0]; x_dat = {4{wd[7:0]}}; ref_mem[a[11:2]][8*a[1:0] +: 8] = wd[7:0]; end
          3'b001:  begin x_enb = 4'b0011 << a[1:0]; x_dat = {2{wd[15:0]}}; ref_mem[a[11:2]][16*a[1] +: 16] = wd[15:0]; end
          default: begin x_enb = 4'b1111; x_dat = wd; ref_mem[a[11:2]] = wd; end
        endcase
        check("w_enb",  {28'h0, mem_w_enb}, {28'h0, x_enb});
        check("w_dat",  mem_w_dat, x_dat);
        check("w_addr", {20'h0, mem_w_addr}, {20'h0, a[11:0]});
        check("w_r_enb", {28'h0, mem_r_enb}, 32'h0);
      end else begin
        check("r_enb",  {28'h0, mem_r_enb}, 32'hF);
        check("r_addr", {20'h0, mem_r_addr}, {22'h0, a[11:2]});
        check("r_w_enb", {28'h0, mem_w_enb}, 32'h0);
      end
      check("resp_early", {31'h0, resp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    repeat (hold) begin
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, sb_q[0].rdata);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'h0, 32'h1);
    end else begin
      e = sb_q.pop_front();
      check("rdata", resp_rdata, e.rdata);
      check("err", {31'h0, resp_err}, {31'h0, e.err});
    end
    check("resp_no_accept", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("idle_ready", {31'h0, req_ready}, 32'h1);
    check("idle_valid", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [2:0] ld_f3 [6];
    logic [2:0] st_f3 [4];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b100};
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_outs", {resp_valid, resp_err, 30'h0} | resp_rdata, 32'h0);
    check("rst_mem", {12'h0, mem_w_enb, mem_r_enb, mem_w_addr} | mem_w_dat | {20'h0, mem_r_addr}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_ready", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0);
    do_req(1'b1, 3'b000, 32'h013, 32'h000000A5, 0);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h010, 32'h80FF1234, 0);
    do_req(1'b0, 3'b000, 32'h013, 32'h0, 0);
    do_req(1'b0, 3'b100, 32'h013, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h000, 32'h80FF1234, 0);
    do_req(1'b0, 3'b001, 32'h002, 32'h0, 0);
    do_req(1'b0, 3'b101, 32'h002, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h006, 32'h0, 0);
    do_req(1'b0, 3'b000, 32'h012, 32'h0, 3);
    do_req(1'b1, 3'b001, 32'h012, 32'h1234ABCD, 0);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, 0);
    do_req(1'b1, 3'b001, 32'h001, 32'h5555, 0);
    do_req(1'b0, 3'b011, 32'h000, 32'h0, 0);
    do_req(1'b1, 3'b100, 32'h000, 32'h77, 0);
    do_req(1'b1, 3'b010, 32'h000, 32'h11111111, 2);

    for (int i = 0; i < 8; i++) do_req(1'b1, 3'b010, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = 32'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_req(1'b1, st_f3[$urandom_range(0, 3)], a, $urandom, 0);
      else                           do_req(1'b0, ld_f3[$urandom_range(0, 5)], a, 32'h0, $urandom_range(0, 2));
    end

    // Reset in the middle of a read: strobes drop at once and no response follows.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_read_enb", {28'h0, mem_r_enb}, 32'hF);
    rst = 1'b1;
    #1;
    check("rst_drop_enb", {24'h0, mem_r_enb, mem_w_enb}, 32'h0);
    check("rst_drop_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rel_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) begin
      check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    check("sb_drained", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
